// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode macros,
// source-mode encodings, fetch-state enum and the fetched-word record.

`ifndef IFU_OPCODES_SVH
`define IFU_OPCODES_SVH
`define NOP   5'b00000
`define ADD   5'b00001
`define SUB   5'b00010
`define LOAD  5'b01100
`define STORE 5'b01101
`define JUMP  5'b10000
`endif

package instruction_fetch_unit_pkg;

   localparam logic [1:0] SRC_REG = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;
   localparam logic [1:0] SRC_IMM = 2'b10;

   typedef enum logic [1:0] {
      F_HI   = 2'd0,
      F_LO   = 2'd1,
      F_OPND = 2'd2,
      F_HOLD = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [7:0]  opnd;
      logic        has_opnd;
   } fetch_word_t;

   // The high byte carries both the opcode [15:11] and source mode [10:9],
   // so the operand decision is known before the low byte arrives.
   function automatic logic needs_operand(input logic [7:0] hi_byte);
      return (hi_byte[2:1] != SRC_REG) || (hi_byte[7:3] == `JUMP);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, program memory and the control state
// machine. master = fetch unit, slave = memory/consumer environment.

interface instruction_fetch_unit_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic [7:0]            mem_rdata;
   logic                  mem_ready;
   logic [15:0]           instruction;
   logic [7:0]            operand;
   logic                  has_operand;
   logic                  instr_valid;
   logic                  instr_ack;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_load_addr;
   logic                  halt;

   modport master (
      output mem_addr, mem_rd,
      input  mem_rdata, mem_ready,
      output instruction, operand, has_operand, instr_valid,
      input  instr_ack,
      output pc,
      input  pc_load, pc_load_addr, halt
   );

   modport slave (
      input  mem_addr, mem_rd,
      output mem_rdata, mem_ready,
      input  instruction, operand, has_operand, instr_valid,
      output instr_ack,
      input  pc,
      output pc_load, pc_load_addr, halt
   );
endinterface

// File: rtl/instruction_fetch_unit_prefetch_buf.sv
// One holding register for a fetched instruction plus its full flag.
// Used as the output stage, and as the prefetch buffer when enabled.

module instruction_fetch_unit_prefetch_buf
   import instruction_fetch_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        load_i,
   input  fetch_word_t data_i,
   input  logic        clear_i,
   output fetch_word_t data_o,
   output logic        full_o
);

   fetch_word_t data_q;
   logic        full_q;

   // Load wins over clear so a same-edge consume-and-refill keeps the slot full.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 16-bit instructions (high byte
// first) plus an optional operand byte from byte-wide program memory, and
// hands them to the control state machine over a valid/ack handshake.
// Build option IFU_PREFETCH_EN adds a one-entry prefetch buffer so fetch of
// the next instruction overlaps with the consumer holding the current one.
//
// state  | meaning
// F_HI   | request high byte (suppressed by halt unless already issued)
// F_LO   | request low byte, decide whether an operand follows
// F_OPND | request operand byte
// F_HOLD | no free slot; wait for the consumer to ack

module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
)(
   input  logic                     clock,
   input  logic                     reset,
   instruction_fetch_unit_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

   fetch_state_t          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [15:0]           stage_q;
   logic                  hi_req_q;

   logic        rd_req;
   logic        beat;
   logic        done;
   logic        ack_take;
   logic        slot_full_d;
   fetch_word_t word_d;
   fetch_word_t out_word;
   logic        out_full;

   // A high-byte request, once raised, is held until accepted even if halt rises.
   assign rd_req = reset && ((state_q == F_HI) ? (!bus.halt || hi_req_q)
                                               : (state_q == F_LO || state_q == F_OPND));
   assign beat     = rd_req && bus.mem_ready && !bus.pc_load;
   assign ack_take = bus.instr_ack && out_full && !bus.pc_load;

   // Assemble the completed instruction on its final byte.
   always_comb begin
      word_d = '0;
      done   = 1'b0;
      if (beat && state_q == F_LO && !needs_operand(stage_q[15:8])) begin
         done         = 1'b1;
         word_d.instr = {stage_q[15:8], bus.mem_rdata};
      end else if (beat && state_q == F_OPND) begin
         done            = 1'b1;
         word_d.instr    = stage_q;
         word_d.opnd     = bus.mem_rdata;
         word_d.has_opnd = 1'b1;
      end
   end

`ifdef IFU_PREFETCH_EN
   fetch_word_t buf_word;
   fetch_word_t out_in;
   logic        buf_full;
   logic        buf_load;
   logic        buf_clear;
   logic        out_load;

   assign buf_clear   = ack_take && buf_full;
   assign buf_load    = done && out_full && !ack_take;
   assign out_load    = buf_clear || (done && (!out_full || ack_take));
   assign out_in      = buf_clear ? buf_word : word_d;
   assign slot_full_d = buf_load || (buf_full && !buf_clear);

   instruction_fetch_unit_prefetch_buf u_out_stage (
      .clk_i   (clock),
      .rst_n_i (reset),
      .flush_i (bus.pc_load),
      .load_i  (out_load),
      .data_i  (out_in),
      .clear_i (ack_take),
      .data_o  (out_word),
      .full_o  (out_full)
   );

   instruction_fetch_unit_prefetch_buf u_buf_stage (
      .clk_i   (clock),
      .rst_n_i (reset),
      .flush_i (bus.pc_load),
      .load_i  (buf_load),
      .data_i  (word_d),
      .clear_i (buf_clear),
      .data_o  (buf_word),
      .full_o  (buf_full)
   );
`else
   assign slot_full_d = done || (out_full && !ack_take);

   instruction_fetch_unit_prefetch_buf u_out_stage (
      .clk_i   (clock),
      .rst_n_i (reset),
      .flush_i (bus.pc_load),
      .load_i  (done),
      .data_i  (word_d),
      .clear_i (ack_take),
      .data_o  (out_word),
      .full_o  (out_full)
   );
`endif

   // Fetch sequencing and PC; a redirect abandons any byte returned alongside it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= F_HI;
         pc_q     <= RESET_PC;
         stage_q  <= '0;
         hi_req_q <= 1'b0;
      end else if (bus.pc_load) begin
         state_q  <= F_HI;
         pc_q     <= bus.pc_load_addr;
         hi_req_q <= 1'b0;
      end else begin
         case (state_q)
            F_HI: begin
               if (beat) begin
                  stage_q[15:8] <= bus.mem_rdata;
                  pc_q          <= pc_q + PC_ONE;
                  hi_req_q      <= 1'b0;
                  state_q       <= F_LO;
               end else begin
                  hi_req_q <= rd_req;
               end
            end
            F_LO: begin
               if (beat) begin
                  stage_q[7:0] <= bus.mem_rdata;
                  pc_q         <= pc_q + PC_ONE;
                  if (needs_operand(stage_q[15:8])) begin
                     state_q <= F_OPND;
                  end else begin
                     state_q <= slot_full_d ? F_HOLD : F_HI;
                  end
               end
            end
            F_OPND: begin
               if (beat) begin
                  pc_q    <= pc_q + PC_ONE;
                  state_q <= slot_full_d ? F_HOLD : F_HI;
               end
            end
            F_HOLD: begin
               if (!slot_full_d) begin
                  state_q <= F_HI;
               end
            end
            default: state_q <= F_HI;
         endcase
      end
   end

   assign bus.mem_rd      = rd_req;
   assign bus.mem_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.instruction = out_word.instr;
   assign bus.operand     = out_word.opnd;
   assign bus.has_operand = out_word.has_opnd;
   assign bus.instr_valid = out_full;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a byte-wide memory model
// whose ready response can be delayed a programmable number of cycles.

module tb_instruction_fetch_unit;

   logic clock;
   logic reset;

   instruction_fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

   instruction_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] mem [256];
   int         delay;
   int         wait_cnt;
   int         n_chk;
   int         n_fail;

   always_comb begin
      bus.mem_ready = bus.mem_rd && (wait_cnt >= delay);
      bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr] : 8'hEE;
   end

   always @(posedge clock) begin
      if (!reset || !bus.mem_rd || bus.mem_ready) wait_cnt <= 0;
      else                                        wait_cnt <= wait_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   task automatic ack_pulse();
      bus.instr_ack = 1'b1;
      cyc();
      bus.instr_ack = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      delay = 0;
      reset = 1'b0;
      bus.halt = 1'b0;
      bus.instr_ack = 1'b0;
      bus.pc_load = 1'b0;
      bus.pc_load_addr = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'hC3;
      mem[8'h00] = 8'h08; mem[8'h01] = 8'h04;
      mem[8'h02] = 8'h64; mem[8'h03] = 8'h04; mem[8'h04] = 8'h2A;
      mem[8'h60] = 8'h80; mem[8'h61] = 8'h12; mem[8'h62] = 8'h34;
      mem[8'h63] = 8'h08; mem[8'h64] = 8'h04;
      mem[8'h40] = 8'h10; mem[8'h41] = 8'h55;
      mem[8'hFF] = 8'h18;
      mem[8'h80] = 8'h08; mem[8'h81] = 8'h04; mem[8'h82] = 8'h10; mem[8'h83] = 8'h55;

      // reset state
      repeat (2) cyc();
      look();
      check_eq("rst_valid", 32'(bus.instr_valid), 0);
      check_eq("rst_mem_rd", 32'(bus.mem_rd), 0);
      check_eq("rst_pc", 32'(bus.pc), 0);
      check_eq("rst_instr", 32'(bus.instruction), 0);
      check_eq("rst_opnd", 32'(bus.operand), 0);
      check_eq("rst_has", 32'(bus.has_operand), 0);

      // ADD reg-source, two bytes, 2-cycle latency; halt raised in F_LO
      reset = 1'b1;
      look();
      check_eq("t1_rd0", 32'(bus.mem_rd), 1);
      check_eq("t1_addr0", 32'(bus.mem_addr), 32'h00);
      check_eq("t1_valid0", 32'(bus.instr_valid), 0);
      cyc(); bus.halt = 1'b1; look();
      check_eq("t1_addr1", 32'(bus.mem_addr), 32'h01);
      check_eq("t1_valid1", 32'(bus.instr_valid), 0);
      cyc(); look();
      check_eq("t1_valid2", 32'(bus.instr_valid), 1);
      check_eq("t1_instr", 32'(bus.instruction), 32'h0804);
      check_eq("t1_has", 32'(bus.has_operand), 0);
      check_eq("t1_opnd", 32'(bus.operand), 0);
      check_eq("t1_pc", 32'(bus.pc), 32'h02);
      check_eq("t1_rd_hold", 32'(bus.mem_rd), 0);
      ack_pulse(); look();
      check_eq("t1_valid_ack", 32'(bus.instr_valid), 0);
      check_eq("t1_halt_rd", 32'(bus.mem_rd), 0);
      cyc(); look();
      check_eq("t1_halt_rd2", 32'(bus.mem_rd), 0);
      check_eq("t1_halt_pc", 32'(bus.pc), 32'h02);

      // LOAD immediate source: operand byte, 3-cycle latency
      bus.halt = 1'b0; look();
      check_eq("t2_addr0", 32'(bus.mem_addr), 32'h02);
      cyc(); bus.halt = 1'b1; look();
      check_eq("t2_addr1", 32'(bus.mem_addr), 32'h03);
      check_eq("t2_valid1", 32'(bus.instr_valid), 0);
      cyc(); look();
      check_eq("t2_addr2", 32'(bus.mem_addr), 32'h04);
      check_eq("t2_rd2", 32'(bus.mem_rd), 1);
      check_eq("t2_valid2", 32'(bus.instr_valid), 0);
      cyc(); look();
      check_eq("t2_valid3", 32'(bus.instr_valid), 1);
      check_eq("t2_instr", 32'(bus.instruction), 32'h6404);
      check_eq("t2_opnd", 32'(bus.operand), 32'h2A);
      check_eq("t2_has", 32'(bus.has_operand), 1);
      check_eq("t2_pc", 32'(bus.pc), 32'h05);

      // redirect together with ack: redirect wins, fields flushed
      bus.instr_ack = 1'b1; bus.pc_load = 1'b1; bus.pc_load_addr = 8'h60;
      cyc();
      bus.instr_ack = 1'b0; bus.pc_load = 1'b0;
      look();
      check_eq("ld_valid", 32'(bus.instr_valid), 0);
      check_eq("ld_has", 32'(bus.has_operand), 0);
      check_eq("ld_opnd", 32'(bus.operand), 0);
      check_eq("ld_pc", 32'(bus.pc), 32'h60);
      check_eq("ld_rd", 32'(bus.mem_rd), 0);

      // JUMP (register source) with ready delayed 3 cycles per byte;
      // a stray ack while nothing is valid must be ignored
      delay = 3; bus.halt = 1'b0;
      for (int b = 0; b < 3; b++) begin
         for (int c = 0; c < 4; c++) begin
            look();
            check_eq("t3_rd", 32'(bus.mem_rd), 1);
            check_eq("t3_addr", 32'(bus.mem_addr), 32'(8'h60 + b));
            check_eq("t3_valid", 32'(bus.instr_valid), 0);
            bus.instr_ack = (b == 0 && c == 1);
            cyc();
            if (b == 0 && c == 3) bus.halt = 1'b1;
         end
      end
      bus.instr_ack = 1'b0;
      look();
      check_eq("t3_valid", 32'(bus.instr_valid), 1);
      check_eq("t3_instr", 32'(bus.instruction), 32'h8012);
      check_eq("t3_opnd", 32'(bus.operand), 32'h34);
      check_eq("t3_has", 32'(bus.has_operand), 1);
      check_eq("t3_pc", 32'(bus.pc), 32'h63);
      ack_pulse();
      delay = 0;

      // pc_load in the same cycle as the low-byte ready: byte dropped
      bus.halt = 1'b0; look();
      check_eq("t4_addr0", 32'(bus.mem_addr), 32'h63);
      cyc(); bus.pc_load = 1'b1; bus.pc_load_addr = 8'h40;
      cyc(); bus.pc_load = 1'b0; look();
      check_eq("t4_valid", 32'(bus.instr_valid), 0);
      check_eq("t4_addr", 32'(bus.mem_addr), 32'h40);
      check_eq("t4_rd", 32'(bus.mem_rd), 1);
      check_eq("t4_pc", 32'(bus.pc), 32'h40);
      cyc(); bus.halt = 1'b1; look();
      check_eq("t4_addr1", 32'(bus.mem_addr), 32'h41);
      cyc(); look();
      check_eq("t4_valid2", 32'(bus.instr_valid), 1);
      check_eq("t4_instr", 32'(bus.instruction), 32'h1055);
      check_eq("t4_pc2", 32'(bus.pc), 32'h42);
      ack_pulse();

      // PC wrap mid-instruction
      bus.pc_load = 1'b1; bus.pc_load_addr = 8'hFF;
      cyc(); bus.pc_load = 1'b0; look();
      check_eq("t5_pc", 32'(bus.pc), 32'hFF);
      check_eq("t5_rd_halt", 32'(bus.mem_rd), 0);
      bus.halt = 1'b0; look();
      check_eq("t5_addr0", 32'(bus.mem_addr), 32'hFF);
      cyc(); bus.halt = 1'b1; look();
      check_eq("t5_addr1", 32'(bus.mem_addr), 32'h00);
      cyc(); look();
      check_eq("t5_valid", 32'(bus.instr_valid), 1);
      check_eq("t5_instr", 32'(bus.instruction), 32'h1808);
      check_eq("t5_pc2", 32'(bus.pc), 32'h01);
      ack_pulse();

`ifdef IFU_PREFETCH_EN
      // prefetch: ack on a full buffer keeps instr_valid high across the edge
      bus.pc_load = 1'b1; bus.pc_load_addr = 8'h80;
      cyc(); bus.pc_load = 1'b0; bus.halt = 1'b0;
      cyc(); cyc(); look();
      check_eq("pf_valid0", 32'(bus.instr_valid), 1);
      check_eq("pf_instr0", 32'(bus.instruction), 32'h0804);
      check_eq("pf_addr", 32'(bus.mem_addr), 32'h82);
      check_eq("pf_rd", 32'(bus.mem_rd), 1);
      cyc(); cyc(); bus.halt = 1'b1; look();
      check_eq("pf_full_rd", 32'(bus.mem_rd), 0);
      check_eq("pf_instr1", 32'(bus.instruction), 32'h0804);
      check_eq("pf_pc", 32'(bus.pc), 32'h84);
      ack_pulse(); look();
      check_eq("pf_valid1", 32'(bus.instr_valid), 1);
      check_eq("pf_instr2", 32'(bus.instruction), 32'h1055);
      ack_pulse(); look();
      check_eq("pf_valid2", 32'(bus.instr_valid), 0);
`endif

      // reset mid-fetch abandons the request
      delay = 3; bus.halt = 1'b0;
      cyc();
      reset = 1'b0; look();
      check_eq("mr_rd_gate", 32'(bus.mem_rd), 0);
      cyc(); look();
      check_eq("mr_pc", 32'(bus.pc), 0);
      check_eq("mr_valid", 32'(bus.instr_valid), 0);
      check_eq("mr_rd", 32'(bus.mem_rd), 0);
      reset = 1'b1; look();
      check_eq("mr_rd_rel", 32'(bus.mem_rd), 1);
      check_eq("mr_addr", 32'(bus.mem_addr), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
